// File: rtl/vga_scan_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_overlay
//  Purpose  : Single-clock raster generator with packed-word pixel fetch,
//             pixel unpacking, crosshair/marker overlay and sync/blank
//             alignment to the pixel data path.
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_overlay #(
  parameter int               PIX_W        = 18,
  parameter int               PIX_PER_WORD = 2,
  parameter int               H_ACTIVE     = 640,
  parameter int               H_FP         = 16,
  parameter int               H_SYNC       = 96,
  parameter int               H_BP         = 48,
  parameter int               V_ACTIVE     = 480,
  parameter int               V_FP         = 11,
  parameter int               V_SYNC       = 2,
  parameter int               V_BP         = 31,
  parameter int               LOG_H        = 10,
  parameter int               LOG_V        = 10,
  parameter int               FETCH_LAT    = 5,
  parameter int               NUM_MARKERS  = 4,
  parameter logic [PIX_W-1:0] MARKER_COLOR = '1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PIX_PER_WORD*PIX_W-1:0] pixel_word,
  input  logic [NUM_MARKERS*LOG_H-1:0]  marker_x,
  input  logic [NUM_MARKERS*LOG_V-1:0]  marker_y,
  input  logic [NUM_MARKERS-1:0]        marker_en,
  input  logic                          crosshair_en,
  output logic                          word_req,
  output logic [LOG_H-1:0]              word_hcount,
  output logic [LOG_V-1:0]              word_vcount,
  output logic [PIX_W-1:0]              pix_out,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          blank,
  output logic                          frame_start
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  // Side-band stages before the output register: fetch latency plus the
  // word capture stage.
  localparam int PIPE_D = FETCH_LAT + 1;

  localparam logic [LOG_H-1:0] H_LAST  = LOG_H'(H_TOT - 1);
  localparam logic [LOG_V-1:0] V_LAST  = LOG_V'(V_TOT - 1);
  localparam logic [LOG_H-1:0] H_ACT_L = LOG_H'(H_ACTIVE);
  localparam logic [LOG_V-1:0] V_ACT_L = LOG_V'(V_ACTIVE);
  localparam logic [LOG_H-1:0] HS_BEG  = LOG_H'(H_ACTIVE + H_FP);
  localparam logic [LOG_H-1:0] HS_END  = LOG_H'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LOG_V-1:0] VS_BEG  = LOG_V'(V_ACTIVE + V_FP);
  localparam logic [LOG_V-1:0] VS_END  = LOG_V'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LOG_H-1:0] H_MID   = LOG_H'(H_ACTIVE / 2);
  localparam logic [LOG_V-1:0] V_MID   = LOG_V'(V_ACTIVE / 2);

  // Raster counters
  logic [LOG_H-1:0] h_q, h_d;
  logic [LOG_V-1:0] v_q, v_d;

  // Overlay shadows, captured at the frame origin
  logic [NUM_MARKERS*LOG_H-1:0] mx_q, mx_d;
  logic [NUM_MARKERS*LOG_V-1:0] my_q, my_d;
  logic [NUM_MARKERS-1:0]       men_q, men_d;
  logic                         xen_q, xen_d;

  // Fetch address hold and return tracking
  logic [LOG_H-1:0]              whc_q, whc_d;
  logic [LOG_V-1:0]              wvc_q, wvc_d;
  logic [FETCH_LAT-1:0]          req_pipe_q, req_pipe_d;
  logic [PIX_PER_WORD*PIX_W-1:0] word_q, word_d;

  // Side-band pipeline aligning timing and overlay decisions with the data
  logic [PIPE_D-1:0] blank_pipe_q, blank_pipe_d;
  logic [PIPE_D-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_D-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_D-1:0] fs_pipe_q, fs_pipe_d;
  logic [PIPE_D-1:0] hit_pipe_q, hit_pipe_d;
  logic [IDX_W-1:0]  idx_pipe_q [PIPE_D];
  logic [IDX_W-1:0]  idx_pipe_d [PIPE_D];

  // Output registers
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;
  logic             fs_q, fs_d;

  // Combinational helpers
  logic             w_active;
  logic             w_hsync_raw;
  logic             w_vsync_raw;
  logic             w_origin;
  logic             w_hit;
  logic             w_req;
  logic             w_slot;
  logic [IDX_W-1:0] w_idx;
  logic [PIX_W-1:0] w_pix_sel;

  // Pixel position inside the fetched word; a new word starts at index 0
  generate
    if (PIX_PER_WORD > 1) begin : g_idx_multi
      assign w_idx = h_q[IDX_W-1:0];
    end else begin : g_idx_single
      assign w_idx = 1'b0;
    end
  endgenerate
  assign w_slot = (w_idx == '0);

  // Next raster position: h wraps each line, v advances on the h wrap
  always_comb begin
    h_d = h_q + LOG_H'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + LOG_V'(1);
    end
  end

  // Undelayed timing flags for the current raster position
  always_comb begin
    w_active    = (h_q < H_ACT_L) && (v_q < V_ACT_L);
    w_hsync_raw = !((h_q >= HS_BEG) && (h_q < HS_END));
    w_vsync_raw = !((v_q >= VS_BEG) && (v_q < VS_END));
    w_origin    = (h_q == '0) && (v_q == '0);
  end

  // Shadow capture and overlay hit test; the origin pixel already sees
  // the freshly sampled inputs so a whole frame uses one consistent set
  always_comb begin
    mx_d  = w_origin ? marker_x     : mx_q;
    my_d  = w_origin ? marker_y     : my_q;
    men_d = w_origin ? marker_en    : men_q;
    xen_d = w_origin ? crosshair_en : xen_q;
    w_hit = xen_d && ((h_q == H_MID) || (v_q == V_MID));
    for (int i = 0; i < NUM_MARKERS; i++) begin
      if (men_d[i] && ((h_q == mx_d[i*LOG_H +: LOG_H]) ||
                       (v_q == my_d[i*LOG_V +: LOG_V]))) begin
        w_hit = 1'b1;
      end
    end
  end

  // Word request, held request address and return-time word capture
  always_comb begin
    w_req         = !reset && w_active && w_slot;
    whc_d         = w_req ? h_q : whc_q;
    wvc_d         = w_req ? v_q : wvc_q;
    req_pipe_d[0] = w_req;
    for (int i = 1; i < FETCH_LAT; i++) begin
      req_pipe_d[i] = req_pipe_q[i-1];
    end
    word_d = req_pipe_q[FETCH_LAT-1] ? pixel_word : word_q;
  end

  // Side-band shift register feeding the output stage
  always_comb begin
    blank_pipe_d[0] = !w_active;
    hs_pipe_d[0]    = w_hsync_raw;
    vs_pipe_d[0]    = w_vsync_raw;
    fs_pipe_d[0]    = w_origin;
    hit_pipe_d[0]   = w_hit;
    idx_pipe_d[0]   = w_idx;
    for (int i = 1; i < PIPE_D; i++) begin
      blank_pipe_d[i] = blank_pipe_q[i-1];
      hs_pipe_d[i]    = hs_pipe_q[i-1];
      vs_pipe_d[i]    = vs_pipe_q[i-1];
      fs_pipe_d[i]    = fs_pipe_q[i-1];
      hit_pipe_d[i]   = hit_pipe_q[i-1];
      idx_pipe_d[i]   = idx_pipe_q[i-1];
    end
  end

  // Unpack the selected pixel and apply blank > overlay > data priority
  always_comb begin
    w_pix_sel = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (idx_pipe_q[PIPE_D-1] == IDX_W'(i)) begin
        w_pix_sel = word_q[i*PIX_W +: PIX_W];
      end
    end
    if (blank_pipe_q[PIPE_D-1]) begin
      pix_out_d = '0;
    end else if (hit_pipe_q[PIPE_D-1]) begin
      pix_out_d = MARKER_COLOR;
    end else begin
      pix_out_d = w_pix_sel;
    end
    hsync_d = hs_pipe_q[PIPE_D-1];
    vsync_d = vs_pipe_q[PIPE_D-1];
    blank_d = blank_pipe_q[PIPE_D-1];
    fs_d    = fs_pipe_q[PIPE_D-1];
  end

  // State update; reset flushes every stage to idle/blank values
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      mx_q         <= '0;
      my_q         <= '0;
      men_q        <= '0;
      xen_q        <= 1'b0;
      whc_q        <= '0;
      wvc_q        <= '0;
      req_pipe_q   <= '0;
      word_q       <= '0;
      blank_pipe_q <= '1;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      fs_pipe_q    <= '0;
      hit_pipe_q   <= '0;
      for (int i = 0; i < PIPE_D; i++) begin
        idx_pipe_q[i] <= '0;
      end
      pix_out_q    <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      blank_q      <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      mx_q         <= mx_d;
      my_q         <= my_d;
      men_q        <= men_d;
      xen_q        <= xen_d;
      whc_q        <= whc_d;
      wvc_q        <= wvc_d;
      req_pipe_q   <= req_pipe_d;
      word_q       <= word_d;
      blank_pipe_q <= blank_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      fs_pipe_q    <= fs_pipe_d;
      hit_pipe_q   <= hit_pipe_d;
      for (int i = 0; i < PIPE_D; i++) begin
        idx_pipe_q[i] <= idx_pipe_d[i];
      end
      pix_out_q    <= pix_out_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      blank_q      <= blank_d;
      fs_q         <= fs_d;
    end
  end

  assign word_req    = w_req;
  assign word_hcount = w_req ? h_q : whc_q;
  assign word_vcount = w_req ? v_q : wvc_q;
  assign pix_out     = pix_out_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_overlay
//  Purpose  : Self-checking bench for vga_scan_overlay on a small raster
//             with a word-returning memory model and a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_overlay;

  localparam int PW   = 8;
  localparam int NPW  = 2;
  localparam int HA   = 8;
  localparam int HF   = 2;
  localparam int HS   = 2;
  localparam int HB   = 2;
  localparam int VA   = 4;
  localparam int VF   = 1;
  localparam int VS   = 1;
  localparam int VB   = 1;
  localparam int LH   = 4;
  localparam int LV   = 3;
  localparam int FL   = 3;
  localparam int NM   = 2;
  localparam int HT   = HA + HF + HS + HB;   // 14
  localparam int VT   = VA + VF + VS + VB;   // 7
  localparam int FT   = HT * VT;             // 98
  localparam int OL   = FL + 2;              // 5
  localparam int LOGN = 2048;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NPW*PW-1:0]    pixel_word;
  logic [NM*LH-1:0]     marker_x;
  logic [NM*LV-1:0]     marker_y;
  logic [NM-1:0]        marker_en;
  logic                 crosshair_en;
  logic                 word_req;
  logic [LH-1:0]        word_hcount;
  logic [LV-1:0]        word_vcount;
  logic [PW-1:0]        pix_out;
  logic                 hsync, vsync, blank, frame_start;

  vga_scan_overlay #(
    .PIX_W(PW), .PIX_PER_WORD(NPW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOG_H(LH), .LOG_V(LV), .FETCH_LAT(FL), .NUM_MARKERS(NM),
    .MARKER_COLOR(8'hFF)
  ) dut (
    .clock(clk), .reset(reset), .pixel_word(pixel_word),
    .marker_x(marker_x), .marker_y(marker_y), .marker_en(marker_en),
    .crosshair_en(crosshair_en), .word_req(word_req),
    .word_hcount(word_hcount), .word_vcount(word_vcount),
    .pix_out(pix_out), .hsync(hsync), .vsync(vsync), .blank(blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int t        = 0;     // cycles since the last reset edge
  int held_h   = 0;
  int held_v   = 0;
  int n_req    = 0;
  int n_fs     = 0;

  // Marker inputs seen on each cycle, indexed by t
  logic [NM*LH-1:0] log_mx [LOGN];
  logic [NM*LV-1:0] log_my [LOGN];
  logic [NM-1:0]    log_en [LOGN];
  logic             log_xh [LOGN];

  typedef struct packed {
    logic          req;
    logic [LH-1:0] h;
    logic [LV-1:0] v;
  } req_t;

  // Memory: answers each request exactly FL cycles later with tagged pixels,
  // and drives noise on every other cycle
  initial begin : memory_model
    req_t q[$];
    req_t e;
    pixel_word = '0;
    forever begin
      @(posedge clk);
      #3;
      q.push_back({word_req, word_hcount, word_vcount});
      pixel_word = 16'($urandom);
      if (q.size() > FL) begin
        e = q.pop_front();
        if (e.req) pixel_word = {1'b0, e.v, e.h + 4'd1, 1'b0, e.v, e.h};
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected output pixel for raster step s, from the frame's origin inputs
  function automatic logic [PW-1:0] ref_pix(int s);
    int h = s % HT;
    int v = (s / HT) % VT;
    int f = s - (s % FT);
    if (!(h < HA && v < VA)) return '0;
    if (log_xh[f] && (h == HA/2 || v == VA/2)) return 8'hFF;
    for (int i = 0; i < NM; i++) begin
      if (log_en[f][i] && (h == int'(log_mx[f][i*LH +: LH]) ||
                           v == int'(log_my[f][i*LV +: LV]))) return 8'hFF;
    end
    return {1'b0, 3'(v), 4'(h)};
  endfunction

  // One clock cycle: inputs already set; check outputs, then advance
  task automatic run_cycle();
    int h, v, s, sh, sv;
    logic exp_req;
    if (t < LOGN) begin
      log_mx[t] = marker_x;
      log_my[t] = marker_y;
      log_en[t] = marker_en;
      log_xh[t] = crosshair_en;
    end
    #1;
    h = t % HT;
    v = (t / HT) % VT;
    exp_req = !reset && h < HA && v < VA && (h % NPW) == 0;
    chk("word_req", word_req, exp_req);
    chk("word_hcount", word_hcount, exp_req ? h : held_h);
    chk("word_vcount", word_vcount, exp_req ? v : held_v);
    if (exp_req) begin
      held_h = h;
      held_v = v;
      n_req++;
    end
    if (t < OL) begin
      chk("pix_out_rst", pix_out, 0);
      chk("hsync_rst", hsync, 1);
      chk("vsync_rst", vsync, 1);
      chk("blank_rst", blank, 1);
      chk("frame_start_rst", frame_start, 0);
    end else begin
      s  = t - OL;
      sh = s % HT;
      sv = (s / HT) % VT;
      chk("pix_out", pix_out, ref_pix(s));
      chk("hsync", hsync, !(sh >= HA + HF && sh < HA + HF + HS));
      chk("vsync", vsync, sv != VA + VF);
      chk("blank", blank, !(sh < HA && sv < VA));
      chk("frame_start", frame_start, (s % FT) == 0);
    end
    if (frame_start === 1'b1) n_fs++;
    @(posedge clk);
    if (reset) begin
      t = 0;
      held_h = 0;
      held_v = 0;
    end else begin
      t++;
    end
    #1;
  endtask

  initial begin : stimulus
    reset        = 1'b1;
    crosshair_en = 1'b0;
    marker_x     = {4'd9, 4'd3};
    marker_y     = {3'd6, 3'd2};
    marker_en    = 2'b01;
    @(posedge clk);
    #1;
    t = 0;

    // Reset held: idle outputs, no requests
    repeat (3) run_cycle();

    // First frame: timing, fetch count, marker x0=3 / y0=2
    reset = 1'b0;
    n_req = 0;
    n_fs  = 0;
    repeat (FT) run_cycle();
    chk("req_per_frame", n_req, 16);

    // Move marker 0 mid-frame; the change must wait for the next frame
    repeat (40) run_cycle();
    marker_x[3:0] = 4'd5;
    repeat (2*FT - 40 + 10) run_cycle();
    chk("frame_start_count", n_fs, 4);

    // Crosshair alone, then crosshair coincident with a marker column
    while (t % FT != 0) run_cycle();
    crosshair_en = 1'b1;
    marker_en    = 2'b00;
    repeat (FT) run_cycle();
    marker_x     = {4'd7, 4'd4};
    marker_en    = 2'b01;
    repeat (FT) run_cycle();

    // Random overlay settings changing at random moments
    repeat (2*FT) begin
      if ($urandom_range(0, 19) == 0) begin
        marker_x     = 8'($urandom);
        marker_y     = 6'($urandom);
        marker_en    = 2'($urandom);
        crosshair_en = 1'($urandom);
      end
      run_cycle();
    end

    // Reset mid-frame at h=6, v=1 for two cycles, then a fresh frame
    while (t % FT != HT + 6) run_cycle();
    reset = 1'b1;
    repeat (2) run_cycle();
    reset = 1'b0;
    n_fs  = 0;
    repeat (FT + 10) run_cycle();
    chk("frame_start_after_reset", n_fs, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
